// File: rtl/dpram_fifo_ctrl.sv
// Streaming FIFO controller in front of a dual-port RAM: port A writes, port B prefetches into a
// two-entry registered output stage. Define DPRAM_FIFO_ALMOST_FULL_EN to add the almost_full output.
module dpram_fifo_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int AF_THRESH  = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  ram_we_a,
    output logic [ADDR_WIDTH-1:0] ram_addr_a,
    output logic [DATA_WIDTH-1:0] ram_din_a,
    output logic                  ram_we_b,
    output logic [ADDR_WIDTH-1:0] ram_addr_b,
    output logic [DATA_WIDTH-1:0] ram_din_b,
    input  logic [DATA_WIDTH-1:0] ram_dout_b,
    output logic [ADDR_WIDTH+1:0] count,
    output logic                  empty,
    output logic                  full
`ifdef DPRAM_FIFO_ALMOST_FULL_EN
    ,
    output logic                  almost_full
`endif
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int PW    = ADDR_WIDTH + 1;
    localparam int CW    = ADDR_WIDTH + 2;

    logic [PW-1:0]         wptr;
    logic [PW-1:0]         rptr;
    logic [PW-1:0]         ram_cnt;
    logic                  rd_pend;
    logic                  skid_valid;
    logic [DATA_WIDTH-1:0] skid_data;
    logic                  push;
    logic                  pop;
    logic                  issue;
    logic [2:0]            stage_occ;
    logic [CW-1:0]         count_next;

    assign ram_cnt    = wptr - rptr;
    assign full       = (ram_cnt == PW'(DEPTH));
    assign s_ready    = !full && !rst;
    assign push       = s_valid && s_ready;
    assign pop        = m_valid && m_ready;
    assign empty      = (count == {CW{1'b0}});

    assign ram_we_a   = push;
    assign ram_addr_a = wptr[ADDR_WIDTH-1:0];
    assign ram_din_a  = s_data;
    assign ram_we_b   = 1'b0;
    assign ram_din_b  = {DATA_WIDTH{1'b0}};
    assign ram_addr_b = rptr[ADDR_WIDTH-1:0];

    // Output-stage slots already claimed (held + in flight) once this cycle's pop is taken out;
    // ram_cnt is registered, so a word written this cycle is never read this cycle.
    assign stage_occ  = {2'b00, m_valid} + {2'b00, skid_valid} + {2'b00, rd_pend} - {2'b00, pop};
    assign issue      = (ram_cnt != {PW{1'b0}}) && (stage_occ < 3'd2);

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + {{(CW-1){1'b0}}, 1'b1};
        end else if (pop && !push) begin
            count_next = count - {{(CW-1){1'b0}}, 1'b1};
        end else begin
            count_next = count;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= {PW{1'b0}};
            rptr  <= {PW{1'b0}};
            count <= {CW{1'b0}};
        end else begin
            wptr  <= wptr + {{(PW-1){1'b0}}, push};
            rptr  <= rptr + {{(PW-1){1'b0}}, issue};
            count <= count_next;
        end
    end

    // A returning read lands in main when main is free (or draining without a skid word), else in skid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_pend    <= 1'b0;
            m_valid    <= 1'b0;
            m_data     <= {DATA_WIDTH{1'b0}};
            skid_valid <= 1'b0;
            skid_data  <= {DATA_WIDTH{1'b0}};
        end else begin
            rd_pend <= issue;
            if (pop) begin
                if (skid_valid) begin
                    m_data     <= skid_data;
                    m_valid    <= 1'b1;
                    skid_valid <= rd_pend;
                    if (rd_pend) begin
                        skid_data <= ram_dout_b;
                    end else begin
                        skid_data <= skid_data;
                    end
                end else if (rd_pend) begin
                    m_data  <= ram_dout_b;
                    m_valid <= 1'b1;
                end else begin
                    m_valid <= 1'b0;
                end
            end else if (rd_pend) begin
                if (!m_valid) begin
                    m_data  <= ram_dout_b;
                    m_valid <= 1'b1;
                end else begin
                    skid_data  <= ram_dout_b;
                    skid_valid <= 1'b1;
                end
            end else begin
                m_valid    <= m_valid;
                skid_valid <= skid_valid;
            end
        end
    end

`ifdef DPRAM_FIFO_ALMOST_FULL_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            almost_full <= 1'b0;
        end else begin
            almost_full <= (count_next >= CW'(AF_THRESH));
        end
    end
`endif

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Self-checking bench for dpram_fifo_ctrl: behavioural RAM, vector table for the latency case,
// directed corner sequences, and randomized traffic against a queue model of the FIFO contents.
module tb_dpram_fifo_ctrl;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int CAP   = DEPTH + 2;
    localparam int AFT   = 14;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_data = 8'h00;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic          ram_we_a;
    logic [AW-1:0] ram_addr_a;
    logic [DW-1:0] ram_din_a;
    logic          ram_we_b;
    logic [AW-1:0] ram_addr_b;
    logic [DW-1:0] ram_din_b;
    logic [DW-1:0] ram_dout_b;
    logic [AW+1:0] count;
    logic          empty;
    logic          full;
`ifdef DPRAM_FIFO_ALMOST_FULL_EN
    logic          almost_full;
`endif

    dpram_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_THRESH(AFT)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .ram_we_a(ram_we_a), .ram_addr_a(ram_addr_a), .ram_din_a(ram_din_a),
        .ram_we_b(ram_we_b), .ram_addr_b(ram_addr_b), .ram_din_b(ram_din_b),
        .ram_dout_b(ram_dout_b),
        .count(count), .empty(empty), .full(full)
`ifdef DPRAM_FIFO_ALMOST_FULL_EN
        , .almost_full(almost_full)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural dual_port_ram: write on A, registered read on B.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (ram_we_a) mem[ram_addr_a] <= ram_din_a;
        ram_dout_b <= mem[ram_addr_b];
    end

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] q[$];
    logic          smp_mv, smp_emp, smp_srdy, smp_full;
    logic [DW-1:0] smp_md;
    logic [AW+1:0] smp_cnt;
    logic          last_push, last_pop;
    logic [DW-1:0] last_pop_data;

    typedef struct {
        logic          sv;
        logic [DW-1:0] sd;
        logic          mr;
        logic          mv;
        logic [DW-1:0] md;
        logic [AW+1:0] cnt;
        logic          emp;
        logic          srdy;
    } vec_t;
    vec_t tbl [7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock cycle: entered at posedge+1, drive, sample at the falling edge, update the model.
    task automatic cyc(input logic sv, input logic [DW-1:0] sd, input logic mr);
        s_valid = sv;
        s_data  = sd;
        m_ready = mr;
        #4;
        smp_mv = m_valid; smp_md = m_data; smp_cnt = count;
        smp_emp = empty; smp_srdy = s_ready; smp_full = full;
        last_push = sv && s_ready;
        last_pop  = m_valid && mr;
        chk("count_model", 32'(count), 32'(q.size()));
        chk("empty_model", 32'(empty), 32'(q.size() == 0));
        chk("ready_vs_full", 32'(s_ready), 32'(!full));
        chk("we_a_on_push", 32'(ram_we_a), 32'(last_push));
`ifdef DPRAM_FIFO_ALMOST_FULL_EN
        chk("almost_full_model", 32'(almost_full), 32'(q.size() >= AFT));
`endif
        if (full) chk("full_occupancy", 32'(count >= 6'(DEPTH)), 32'd1);
        if (last_push) chk("push_room", 32'(q.size() < CAP), 32'd1);
        if (last_pop) begin
            last_pop_data = m_data;
            if (q.size() == 0) begin
                chk("pop_from_empty", 32'd1, 32'd0);
            end else begin
                chk("m_data_order", 32'(m_data), 32'(q[0]));
                void'(q.pop_front());
            end
        end
        if (last_push) q.push_back(sd);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 100) begin
            cyc(1'b0, 8'h00, 1'b1);
            n++;
        end
        chk("drain_done", 32'(q.size()), 32'd0);
        cyc(1'b0, 8'h00, 1'b1);
    endtask

    task automatic push_word(input logic [DW-1:0] d, input logic mr);
        int n;
        n = 0;
        last_push = 1'b0;
        while (!last_push && n < 20) begin
            cyc(1'b1, d, mr);
            n++;
        end
        chk("push_accepted", 32'(last_push), 32'd1);
    endtask

    initial begin
        logic [DW-1:0] nd;
        int pushed, popped_n, n;

        tbl[0] = '{1'b1, 8'hA5, 1'b1, 1'b0, 8'h00, 6'd0, 1'b1, 1'b1};
        tbl[1] = '{1'b1, 8'h5A, 1'b1, 1'b0, 8'h00, 6'd1, 1'b0, 1'b1};
        tbl[2] = '{1'b1, 8'h3C, 1'b1, 1'b0, 8'h00, 6'd2, 1'b0, 1'b1};
        tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'hA5, 6'd3, 1'b0, 1'b1};
        tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h5A, 6'd2, 1'b0, 1'b1};
        tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h3C, 6'd1, 1'b0, 1'b1};
        tbl[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 6'd0, 1'b1, 1'b1};

        // Reset state while rst is held.
        #12;
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_data", 32'(m_data), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("ram_we_b", 32'(ram_we_b), 32'd0);
        chk("ram_din_b", 32'(ram_din_b), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Test 1: three-word latency/order vectors.
        for (int i = 0; i < 7; i++) begin
            cyc(tbl[i].sv, tbl[i].sd, tbl[i].mr);
            chk($sformatf("t1_m_valid[%0d]", i), 32'(smp_mv), 32'(tbl[i].mv));
            if (tbl[i].mv) chk($sformatf("t1_m_data[%0d]", i), 32'(smp_md), 32'(tbl[i].md));
            chk($sformatf("t1_count[%0d]", i), 32'(smp_cnt), 32'(tbl[i].cnt));
            chk($sformatf("t1_empty[%0d]", i), 32'(smp_emp), 32'(tbl[i].emp));
            chk($sformatf("t1_s_ready[%0d]", i), 32'(smp_srdy), 32'(tbl[i].srdy));
        end

        // Test 2: fill to capacity with the consumer stalled, then offer a refused word.
        for (int i = 0; i < CAP; i++) push_word(8'(i), 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 8'hFF, 1'b0);
            chk("t2_count_full", 32'(smp_cnt), 32'(CAP));
            chk("t2_full", 32'(smp_full), 32'd1);
            chk("t2_refused", 32'(smp_srdy), 32'd0);
        end

        // Test 3: from full, continuous push and pop; first cycle pops only (RAM full), then 1:1.
        nd = 8'h12;
        for (int i = 0; i < 30; i++) begin
            cyc(1'b1, nd, 1'b1);
            if (last_push) nd = nd + 8'h01;
            if (last_pop) chk("t3_no_refused_word", 32'(last_pop_data != 8'hFF), 32'd1);
            chk("t3_pop", 32'(last_pop), 32'd1);
            if (i >= 1) begin
                chk("t3_push", 32'(last_push), 32'd1);
                chk("t3_steady_count", 32'(smp_cnt), 32'(CAP - 1));
            end
        end
        drain();

        // Test 4: 40 incrementing words with random gaps on both sides.
        pushed = 0;
        popped_n = 0;
        n = 0;
        while (popped_n < 40 && n < 2000) begin
            cyc((pushed < 40) && ($urandom_range(0, 3) != 0), 8'(pushed), $urandom_range(0, 2) != 0);
            if (last_push) pushed++;
            if (last_pop) begin
                chk("t4_sequence", 32'(last_pop_data), 32'(popped_n));
                popped_n++;
            end
            n++;
        end
        chk("t4_all_out", 32'(popped_n), 32'd40);

        // Random data and handshakes, checked by the queue model.
        for (int i = 0; i < 300; i++) begin
            cyc($urandom_range(0, 1) == 1, 8'($urandom()), $urandom_range(0, 3) != 0);
        end
        drain();

        // Test 5: reset mid-stream with seven words held.
        for (int i = 0; i < 7; i++) push_word(8'h40 + 8'(i), 1'b0);
        cyc(1'b0, 8'h00, 1'b0);
        chk("t5_count7", 32'(smp_cnt), 32'd7);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_async_m_valid", 32'(m_valid), 32'd0);
        chk("t5_async_count", 32'(count), 32'd0);
        chk("t5_async_empty", 32'(empty), 32'd1);
        chk("t5_async_s_ready", 32'(s_ready), 32'd0);
        q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(1'b1, 8'h3C, 1'b1);
        chk("t5_push_after_rst", 32'(last_push), 32'd1);
        n = 0;
        last_pop = 1'b0;
        while (!last_pop && n < 10) begin
            cyc(1'b0, 8'h00, 1'b1);
            n++;
        end
        chk("t5_popped", 32'(last_pop), 32'd1);
        chk("t5_first_out", 32'(last_pop_data), 32'h3C);
        drain();

`ifdef DPRAM_FIFO_ALMOST_FULL_EN
        // Test 6: almost_full tracks count >= 14 with the consumer stalled.
        for (int i = 0; i < AFT; i++) push_word(8'h80 + 8'(i), 1'b0);
        cyc(1'b0, 8'h00, 1'b0);
        chk("t6_count14", 32'(smp_cnt), 32'(AFT));
        chk("t6_af_set", 32'(almost_full), 32'd1);
        cyc(1'b0, 8'h00, 1'b1);
        chk("t6_pop", 32'(last_pop), 32'd1);
        chk("t6_count13", 32'(count), 32'(AFT - 1));
        chk("t6_af_clear", 32'(almost_full), 32'd0);
        drain();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
